onfi_sdr_sequencer: RTL and testbench
=====================================

Name: onfi_sdr_sequencer

Overview:
Host-side ONFI SDR (asynchronous-interface) bus sequencer. It turns a stream of single-cycle bus operations (command, address, data-in, data-out, wait-ready, deselect) into correctly timed CE#/CLE/ALE/WE#/RE#/IO waveforms on one NAND target, with timings set by parameters. It waits on R/B# with a timeout. It sits between the cocotb-driven test harness or host logic and the NAND pins.

Parameters:
T_SETUP, 2, cycles CE/CLE/ALE/IO are stable before the WE#/RE# falling edge (min 1)
T_WP, 3, WE# low cycles (min 1)
T_WH, 2, WE# high hold cycles after rising edge (min 1)
T_RP, 3, RE# low cycles (min 1)
T_REH, 2, RE# high hold cycles after rising edge (min 1)
T_WB, 5, cycles after a CMD WE# rise before R/B# may be sampled (min 1)
T_CEH, 2, CE# high cycles for DESELECT (min 1)
TIMEOUT_CYC, 100000, max WAIT_RDY cycles before timeout (min 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  operation request valid
req_ready  out  1  sequencer can accept an operation
req_op  in  3  0 CMD, 1 ADDR, 2 DIN, 3 DOUT, 4 WAIT_RDY, 5 DESELECT, 6-7 NOP
req_data  in  8  command/address/write byte
rsp_valid  out  1  one-cycle pulse: DOUT or WAIT_RDY completed
rsp_data  out  8  byte read (DOUT), else 0
rsp_timeout  out  1  qualifies rsp_valid: WAIT_RDY timed out
busy  out  1  not IDLE
wp_n_cfg  in  1  write-protect level, passed through
CE_x_n  out  1  chip enable
CLE_x  out  1  command latch enable
ALE_x  out  1  address latch enable
WE_x_n  out  1  write enable
RE_x_n  out  1  read enable
WP_x_n  out  1  equals wp_n_cfg (combinational)
io_out  out  8  IO[7:0] drive value
io_oe  out  1  IO output enable (tristate in the wrapper)
io_in  in  8  IO[7:0] sampled value
RB_x_n  in  1  ready/busy#, asynchronous

Behaviour:
- Reset values (async, any state): CE_x_n=1, CLE_x=0, ALE_x=0, WE_x_n=1, RE_x_n=1, io_out=0, io_oe=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, busy=0, state=IDLE, tWB counter=0, R/B synchroniser=1 (ready).
- Reset mid-operation aborts the operation. No response is issued.
- req_ready=1 only in IDLE while out of reset. Acceptance happens on the edge where req_valid&&req_ready; req_op and req_data are captured then.
- CMD/ADDR/DIN, from the next cycle:
  - SETUP for T_SETUP cycles: CE_x_n=0; CLE_x=1 for CMD, ALE_x=1 for ADDR; io_out=data; io_oe=1; WE high.
  - PULSE for T_WP cycles: WE_x_n=0.
  - HOLD for T_WH cycles: WE high, CLE/ALE/io held.
  - Then IDLE with CLE=ALE=0 and io_oe=0. Total busy time = T_SETUP+T_WP+T_WH.
- DOUT:
  - SETUP (io_oe=0), then RE_x_n=0 for T_RP cycles.
  - io_in is captured on the last RE-low cycle.
  - T_REH hold follows. rsp_valid pulses for 1 cycle on the first IDLE cycle with rsp_data=captured byte.
- CE_x_n stays 0 after any bus op until DESELECT. DESELECT drives CE_x_n=1 for T_CEH cycles, then IDLE. DESELECT while already deselected behaves the same.
- tWB: reloaded to T_WB on each CMD WE# rising edge and decrements to 0 every cycle, independent of state.
- WAIT_RDY:
  - Waits until tWB==0, then until the synchronised R/B#==1. Response on completion: rsp_timeout=0.
  - The cycle counter starts at acceptance. If it reaches TIMEOUT_CYC, the op completes with rsp_valid=1, rsp_timeout=1.
  - Ready and timeout in the same cycle: ready wins.
- R/B# uses a 2-flop synchroniser, so latency is 2 cycles.
- NOP: accepted and complete in 1 cycle. No pin activity, no response.
- No response backpressure. rsp_valid is never asserted twice for one op.
- Timing counters are wide enough for the maximum parameter and saturate-safe. No wrap is permitted.

Decomposition:
- onfi_pkg holds:
  - the op encoding constants (OP_CMD..OP_NOP);
  - the state enum (IDLE, SETUP, PULSE, HOLD, CEH, WB_WAIT, RB_WAIT, RESP);
  - a clog2-based counter-width function.
- Sub-module onfi_rb_sync holds the 2-flop R/B# synchroniser (reset to 1). The tWB and timeout counters stay in the sequencer.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles, then release -> CE_x_n=1, WE_x_n=1, RE_x_n=1, io_oe=0, req_ready=1 one cycle after release.
- CMD 0xFF with defaults -> CLE=1 and io_out=0xFF for 7 cycles. WE_x_n low for exactly 3 cycles starting 2 cycles after acceptance. req_ready returns after 7 cycles.
- CMD 0x00, ADDR 0x00 ×5, CMD 0x30, then WAIT_RDY with RB_x_n low for 40 cycles -> rsp_valid with rsp_timeout=0 no earlier than 5 cycles after 0x30's WE# rise and 2 cycles after RB_x_n rises.
- DOUT with io_in=0xA5 stable -> RE_x_n low for 3 cycles, then rsp_valid pulse with rsp_data=0xA5. io_oe stays 0 throughout.
- WAIT_RDY with TIMEOUT_CYC=20 and RB_x_n stuck low -> rsp_valid, rsp_timeout=1, 20 cycles after acceptance.
- Assert rst_n=0 during PULSE of a DIN -> WE_x_n=1, io_oe=0, CE_x_n=1 immediately (asynchronously), and no rsp_valid after release.

Source files
------------

// File: rtl/onfi_pkg.sv
// Shared definitions for the ONFI SDR bus sequencer: op codes, FSM states,
// and helpers used to size timing counters.
package onfi_pkg;

  localparam logic [2:0] OP_CMD      = 3'd0;
  localparam logic [2:0] OP_ADDR     = 3'd1;
  localparam logic [2:0] OP_DIN      = 3'd2;
  localparam logic [2:0] OP_DOUT     = 3'd3;
  localparam logic [2:0] OP_WAIT_RDY = 3'd4;
  localparam logic [2:0] OP_DESELECT = 3'd5;
  localparam logic [2:0] OP_NOP      = 3'd6;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    CEH,
    WB_WAIT,
    RB_WAIT,
    RESP
  } state_t;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/onfi_rb_sync.sv
// Two-flop synchroniser for the asynchronous NAND ready/busy# pin.
// Resets to "ready" so a freshly reset sequencer never sees a false busy.
module onfi_rb_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rb_n_async,
  output logic rb_ready
);

  logic meta_q, sync_q;

  // Shift the raw pin through two flops before anyone looks at it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rb_n_async;
      sync_q <= meta_q;
    end
  end

  assign rb_ready = sync_q;

endmodule

// File: rtl/onfi_sdr_sequencer.sv
// Host-side ONFI SDR sequencer: converts single-cycle bus operations into
// timed CE#/CLE/ALE/WE#/RE#/IO waveforms and waits on R/B# with a timeout.
module onfi_sdr_sequencer
  import onfi_pkg::*;
#(
  parameter int unsigned T_SETUP     = 2,
  parameter int unsigned T_WP        = 3,
  parameter int unsigned T_WH        = 2,
  parameter int unsigned T_RP        = 3,
  parameter int unsigned T_REH       = 2,
  parameter int unsigned T_WB        = 5,
  parameter int unsigned T_CEH       = 2,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  output logic       busy,
  input  logic       wp_n_cfg,
  output logic       CE_x_n,
  output logic       CLE_x,
  output logic       ALE_x,
  output logic       WE_x_n,
  output logic       RE_x_n,
  output logic       WP_x_n,
  output logic [7:0] io_out,
  output logic       io_oe,
  input  logic [7:0] io_in,
  input  logic       RB_x_n
);

  localparam int unsigned T_MAX = max_u(max_u(max_u(T_SETUP, T_WP), max_u(T_WH, T_RP)),
                                        max_u(T_REH, T_CEH));
  localparam int unsigned CNT_W = cnt_width(T_MAX);
  localparam int unsigned TWB_W = cnt_width(T_WB);
  localparam int unsigned TMO_W = cnt_width(TIMEOUT_CYC);

  // Phase counters are loaded with length-1 and the phase ends at zero.
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] WP_LD     = CNT_W'(T_WP - 1);
  localparam logic [CNT_W-1:0] WH_LD     = CNT_W'(T_WH - 1);
  localparam logic [CNT_W-1:0] RP_LD     = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] REH_LD    = CNT_W'(T_REH - 1);
  localparam logic [CNT_W-1:0] CEH_LD    = CNT_W'(T_CEH - 1);
  localparam logic [TWB_W-1:0] TWB_LD    = TWB_W'(T_WB);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYC);

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TWB_W-1:0] twb_q, twb_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             ready_q, ready_d, busy_q, busy_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic             ce_n_q, ce_n_d, cle_q, cle_d, ale_q, ale_d;
  logic             we_n_q, we_n_d, re_n_q, re_n_d, io_oe_q, io_oe_d;
  logic [7:0]       io_out_q, io_out_d;
  logic             rb_ready;

  onfi_rb_sync u_rb_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .rb_n_async(RB_x_n),
    .rb_ready  (rb_ready)
  );

  // Next-state and next-pin computation for the whole sequencer.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    ce_n_d        = ce_n_q;
    cle_d         = cle_q;
    ale_d         = ale_q;
    we_n_d        = we_n_q;
    re_n_d        = re_n_q;
    io_oe_d       = io_oe_q;
    io_out_d      = io_out_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = 8'h00;
    rsp_timeout_d = 1'b0;
    // tWB free-runs down to zero regardless of state; timeout counter saturates.
    twb_d = (twb_q != '0) ? twb_q - TWB_W'(1) : '0;
    tmo_d = (tmo_q != TMO_LIMIT) ? tmo_q + TMO_W'(1) : tmo_q;

    case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          op_d = req_op;
          case (req_op)
            OP_CMD, OP_ADDR, OP_DIN: begin
              state_d  = SETUP;
              cnt_d    = SETUP_LD;
              ce_n_d   = 1'b0;
              cle_d    = (req_op == OP_CMD);
              ale_d    = (req_op == OP_ADDR);
              io_out_d = req_data;
              io_oe_d  = 1'b1;
            end
            OP_DOUT: begin
              state_d = SETUP;
              cnt_d   = SETUP_LD;
              ce_n_d  = 1'b0;
              cle_d   = 1'b0;
              ale_d   = 1'b0;
              io_oe_d = 1'b0;
            end
            OP_WAIT_RDY: begin
              state_d = WB_WAIT;
              tmo_d   = TMO_W'(1);
            end
            OP_DESELECT: begin
              state_d = CEH;
              cnt_d   = CEH_LD;
              ce_n_d  = 1'b1;
            end
            default: ; // NOP: accepted and finished in the same cycle
          endcase
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = PULSE;
          if (op_q == OP_DOUT) begin
            re_n_d = 1'b0;
            cnt_d  = RP_LD;
          end else begin
            we_n_d = 1'b0;
            cnt_d  = WP_LD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          if (op_q == OP_DOUT) begin
            re_n_d  = 1'b1;
            rdata_d = io_in;
            cnt_d   = REH_LD;
          end else begin
            we_n_d = 1'b1;
            cnt_d  = WH_LD;
            if (op_q == OP_CMD) twb_d = TWB_LD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cle_d   = 1'b0;
          ale_d   = 1'b0;
          io_oe_d = 1'b0;
          if (op_q == OP_DOUT) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rdata_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CEH: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      WB_WAIT, RB_WAIT: begin
        // Ready is checked before the timeout so a tie resolves as ready.
        if ((twb_q == '0) && rb_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
        end else if (tmo_q == TMO_LIMIT) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
        end else if (twb_q == '0) begin
          state_d = RB_WAIT;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // Register every state bit and every pin so outputs are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      op_q          <= OP_NOP;
      cnt_q         <= '0;
      twb_q         <= '0;
      tmo_q         <= '0;
      rdata_q       <= 8'h00;
      ready_q       <= 1'b0;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 8'h00;
      rsp_timeout_q <= 1'b0;
      ce_n_q        <= 1'b1;
      cle_q         <= 1'b0;
      ale_q         <= 1'b0;
      we_n_q        <= 1'b1;
      re_n_q        <= 1'b1;
      io_oe_q       <= 1'b0;
      io_out_q      <= 8'h00;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      cnt_q         <= cnt_d;
      twb_q         <= twb_d;
      tmo_q         <= tmo_d;
      rdata_q       <= rdata_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      ce_n_q        <= ce_n_d;
      cle_q         <= cle_d;
      ale_q         <= ale_d;
      we_n_q        <= we_n_d;
      re_n_q        <= re_n_d;
      io_oe_q       <= io_oe_d;
      io_out_q      <= io_out_d;
    end
  end

  assign req_ready   = ready_q;
  assign busy        = busy_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign CE_x_n      = ce_n_q;
  assign CLE_x       = cle_q;
  assign ALE_x       = ale_q;
  assign WE_x_n      = we_n_q;
  assign RE_x_n      = re_n_q;
  assign io_oe       = io_oe_q;
  assign io_out      = io_out_q;
  assign WP_x_n      = wp_n_cfg;

endmodule

// File: tb/tb_onfi_sdr_sequencer.sv
// Self-checking bench for onfi_sdr_sequencer: directed operations, with
// responses checked by a scoreboard monitor against queued expectations.
module tb_onfi_sdr_sequencer;

  localparam logic [2:0] OP_CMD = 3'd0, OP_ADDR = 3'd1, OP_DIN = 3'd2, OP_DOUT = 3'd3,
                         OP_WAIT = 3'd4, OP_DESEL = 3'd5, OP_NOP = 3'd6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, req_valid, wp_n_cfg, rb_n;
  logic [2:0] req_op;
  logic [7:0] req_data, io_in;
  logic       req_ready, rsp_valid, rsp_timeout, busy;
  logic [7:0] rsp_data, io_out;
  logic       ce_n, cle, ale, we_n, re_n, wp_n, io_oe;

  // Second instance with a short timeout, used only for the timeout case.
  logic       t_req_valid, t_rb_n;
  logic       t_req_ready, t_rsp_valid, t_rsp_timeout, t_busy;
  logic [7:0] t_rsp_data, t_io_out;
  logic       t_ce_n, t_cle, t_ale, t_we_n, t_re_n, t_wp_n, t_io_oe;

  onfi_sdr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .busy(busy), .wp_n_cfg(wp_n_cfg), .CE_x_n(ce_n),
    .CLE_x(cle), .ALE_x(ale), .WE_x_n(we_n), .RE_x_n(re_n), .WP_x_n(wp_n),
    .io_out(io_out), .io_oe(io_oe), .io_in(io_in), .RB_x_n(rb_n)
  );

  onfi_sdr_sequencer #(.TIMEOUT_CYC(20)) dut_to (
    .clk(clk), .rst_n(rst_n), .req_valid(t_req_valid), .req_ready(t_req_ready),
    .req_op(req_op), .req_data(req_data), .rsp_valid(t_rsp_valid), .rsp_data(t_rsp_data),
    .rsp_timeout(t_rsp_timeout), .busy(t_busy), .wp_n_cfg(wp_n_cfg), .CE_x_n(t_ce_n),
    .CLE_x(t_cle), .ALE_x(t_ale), .WE_x_n(t_we_n), .RE_x_n(t_re_n), .WP_x_n(t_wp_n),
    .io_out(t_io_out), .io_oe(t_io_oe), .io_in(io_in), .RB_x_n(t_rb_n)
  );

  typedef struct {
    logic [7:0] data;
    logic       tmo;
    int         lo;
    int         hi;
  } exp_t;

  exp_t q_main[$];
  exp_t q_to[$];
  exp_t e_main, e_to;

  int cyc = 0;
  int checks = 0;
  int passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, req, req, cyc);
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act >= lo && act <= hi) passes++;
    else $display("FAIL %s: got %0d expected in [%0d,%0d]", name, act, lo, hi);
  endtask

  // Scoreboard monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (q_main.size() == 0) begin
        checks++;
        $display("FAIL unexpected_rsp: got rsp_valid data=0x%0h expected none at cycle %0d",
                 rsp_data, cyc);
      end else begin
        e_main = q_main.pop_front();
        $display("rsp main: data=0x%0h timeout=%0d cycle=%0d", rsp_data, rsp_timeout, cyc);
        chk("rsp_data", int'(rsp_data), int'(e_main.data));
        chk("rsp_timeout", int'(rsp_timeout), int'(e_main.tmo));
        chk_range("rsp_cycle", cyc, e_main.lo, e_main.hi);
      end
    end
    if (t_rsp_valid) begin
      if (q_to.size() == 0) begin
        checks++;
        $display("FAIL unexpected_rsp_to: got rsp_valid expected none at cycle %0d", cyc);
      end else begin
        e_to = q_to.pop_front();
        $display("rsp to: data=0x%0h timeout=%0d cycle=%0d", t_rsp_data, t_rsp_timeout, cyc);
        chk("to_rsp_data", int'(t_rsp_data), int'(e_to.data));
        chk("to_rsp_timeout", int'(t_rsp_timeout), int'(e_to.tmo));
        chk_range("to_rsp_cycle", cyc, e_to.lo, e_to.hi);
      end
    end
  end

  // Wait (bounded) for ready, present one op, return the acceptance cycle.
  task automatic issue(input logic [2:0] op, input logic [7:0] d, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      $display("FAIL issue_ready: got req_ready=0 expected 1 within 300 cycles");
    end
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    @(posedge clk);
    #1;
    acc       = cyc;
    req_valid = 1'b0;
    $display("issue op=%0d data=0x%0h accepted at cycle %0d", op, d, acc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int a, a30, r, at;
    int cle_n, we_lo, we_first, re_lo, oe_hi, ce_hi;
    logic rdy6, rdy7;

    rst_n = 1'b0; req_valid = 1'b0; t_req_valid = 1'b0; req_op = OP_NOP;
    req_data = 8'h00; io_in = 8'h00; wp_n_cfg = 1'b1; rb_n = 1'b1; t_rb_n = 1'b0;

    // Reset state.
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_ce_n", ce_n, 1);
    chk("rst_we_n", we_n, 1);
    chk("rst_re_n", re_n, 1);
    chk("rst_io_oe", io_oe, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("wp_pass", wp_n, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);

    // CMD 0xFF waveform.
    issue(OP_CMD, 8'hFF, a);
    cle_n = 0; we_lo = 0; we_first = -1; rdy6 = 1'b1; rdy7 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (cle && io_oe && io_out == 8'hFF) cle_n++;
      if (!we_n) begin
        if (we_first < 0) we_first = k;
        we_lo++;
      end
      if (k == 6) rdy6 = req_ready;
      if (k == 7) rdy7 = req_ready;
    end
    chk("cmd_cle_cycles", cle_n, 7);
    chk("cmd_we_low_cycles", we_lo, 3);
    chk("cmd_we_first", we_first, 2);
    chk("cmd_ready_k6", rdy6, 0);
    chk("cmd_ready_k7", rdy7, 1);
    chk("cmd_ce_held", ce_n, 0);
    chk("cmd_cle_idle", cle, 0);

    // Read-page style sequence followed by WAIT_RDY.
    issue(OP_CMD, 8'h00, a);
    for (int i = 0; i < 5; i++) issue(OP_ADDR, 8'h00, a);
    issue(OP_CMD, 8'h30, a30);
    rb_n = 1'b0;
    issue(OP_WAIT, 8'h00, a);
    repeat (40) @(negedge clk);
    rb_n = 1'b1;
    r = cyc;
    q_main.push_back('{data: 8'h00, tmo: 1'b0,
                       lo: ((r + 2) > (a30 + 10)) ? (r + 2) : (a30 + 10), hi: r + 4});

    // DOUT read of 0xA5.
    io_in = 8'hA5;
    issue(OP_DOUT, 8'h00, a);
    q_main.push_back('{data: 8'hA5, tmo: 1'b0, lo: a + 7, hi: a + 7});
    re_lo = 0; oe_hi = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (!re_n) re_lo++;
      if (io_oe) oe_hi++;
    end
    chk("dout_re_low_cycles", re_lo, 3);
    chk("dout_io_oe_cycles", oe_hi, 0);

    // DESELECT: CE high for T_CEH, then ready.
    issue(OP_DESEL, 8'h00, a);
    ce_hi = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (ce_n) ce_hi++;
      if (k == 1) chk("desel_ready_k1", req_ready, 0);
    end
    @(negedge clk);
    chk("desel_ce_cycles", ce_hi, 2);
    chk("desel_ready_k2", req_ready, 1);

    // NOP: no busy time, no pin activity.
    issue(OP_NOP, 8'h00, a);
    @(negedge clk);
    chk("nop_ready", req_ready, 1);
    chk("nop_busy", busy, 0);
    chk("nop_ce_n", ce_n, 1);

    // WAIT_RDY timeout on the short-timeout instance.
    @(negedge clk);
    req_op = OP_WAIT; req_data = 8'h00; t_req_valid = 1'b1;
    @(posedge clk);
    #1;
    at = cyc;
    t_req_valid = 1'b0;
    $display("issue op=4 to timeout instance accepted at cycle %0d", at);
    q_to.push_back('{data: 8'h00, tmo: 1'b1, lo: at + 20, hi: at + 20});
    repeat (30) @(negedge clk);

    // Reset in the middle of a DIN write pulse.
    issue(OP_DIN, 8'h5A, a);
    repeat (4) @(negedge clk);
    chk("din_we_low", we_n, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we_n", we_n, 1);
    chk("abort_io_oe", io_oe, 0);
    chk("abort_ce_n", ce_n, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_ready", req_ready, 1);

    chk("main_queue_empty", q_main.size(), 0);
    chk("to_queue_empty", q_to.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
